// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and byte helpers for mem_ctrl and its byte sequencer.
package mem_ctrl_pkg;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_HI_DEF = 2'b11;

  // Size code 3 is illegal and is handled as a word.
  function automatic logic [2:0] byte_cnt(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_seq.sv
// Walks addr..addr+N-1 one RAM cycle at a time, packing read bytes and unpacking store bytes.
// mem_wr is gated combinationally so a frozen or IO-stalled byte is never written twice.
module mem_ctrl_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter logic [1:0] IO_HI       = IO_HI_DEF,
  parameter bit         IO_STALL_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        start_n,
  input  logic              start_wr,
  input  logic [31:0]       start_wdata,
  input  logic              run,
  input  logic              io_full,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              fin,
  output logic [31:0]       rdata
);

  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic        wr_q;
  logic        wr_en_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [1:0]  cap_idx;
  logic        stall;

  // cnt is the 1-based BUSY cycle; read byte cnt-2 arrives on mem_din this cycle.
  assign cap_idx = cnt[1:0] - 2'd2;
  assign stall   = IO_STALL_EN & wr_en_q & io_full & (mem_a[17:16] == IO_HI);
  assign mem_wr  = wr_en_q & rdy & ~stall;
  assign fin     = wr_q ? ((cnt == n_q) & ~stall) : (cnt == n_q + 3'd1);
  assign rdata   = put_byte(buf_q, cap_idx, mem_din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 3'd0;
      n_q      <= 3'd0;
      wr_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      wdata_q  <= 32'd0;
      buf_q    <= 32'd0;
      mem_a    <= '0;
      mem_dout <= 8'd0;
    end else if (rdy) begin
      if (start) begin
        cnt     <= 3'd1;
        n_q     <= start_n;
        wr_q    <= start_wr;
        wr_en_q <= start_wr;
        wdata_q <= start_wdata;
        buf_q   <= 32'd0;
        mem_a   <= start_addr;
        if (start_wr) mem_dout <= start_wdata[7:0];
      end else if (run) begin
        if (wr_q) begin
          if (!stall) begin
            if (cnt == n_q) begin
              wr_en_q <= 1'b0;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= mem_a + {{(ADDR_W-1){1'b0}}, 1'b1};
              mem_dout <= get_byte(wdata_q, cnt[1:0]);
            end
          end
        end else begin
          if (cnt >= 3'd2) buf_q <= rdata;
          if (cnt < n_q) mem_a <= mem_a + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Fair icache/LSB arbiter over the byte-wide synchronous RAM bus; owns clear and valid logic.
// Define MC_IO_STALL_EN to hold IO-region store bytes while io_buffer_full is set.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_valid,
  output logic [31:0]       lsb_rdata
);

`ifdef MC_IO_STALL_EN
  localparam bit IO_STALL_EN = 1'b1;
`else
  localparam bit IO_STALL_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic        last_lsb;
  logic        gnt_lsb;
  logic        gnt_wr;
  logic        pick_lsb;
  logic        go;
  logic        fin;
  logic [31:0] rdata;

  // On a tie the side that was not served last takes the bus.
  assign pick_lsb = lsb_req & (~inst_req | ~last_lsb);
  assign go       = (state == MC_IDLE) & (inst_req | lsb_req) & ~clear;

  mem_ctrl_byte_seq #(
    .ADDR_W      (ADDR_W),
    .IO_HI       (IO_HI),
    .IO_STALL_EN (IO_STALL_EN)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .start       (go),
    .start_addr  (pick_lsb ? lsb_addr : inst_addr),
    .start_n     (pick_lsb ? byte_cnt(lsb_size) : 3'd4),
    .start_wr    (pick_lsb & lsb_wr),
    .start_wdata (lsb_wdata),
    .run         (state == MC_BUSY),
    .io_full     (io_buffer_full),
    .mem_din     (mem_din),
    .mem_a       (mem_a),
    .mem_dout    (mem_dout),
    .mem_wr      (mem_wr),
    .fin         (fin),
    .rdata       (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MC_IDLE;
      last_lsb   <= 1'b1;
      gnt_lsb    <= 1'b0;
      gnt_wr     <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= 32'd0;
      lsb_valid  <= 1'b0;
      lsb_rdata  <= 32'd0;
    end else if (rdy) begin
      inst_valid <= 1'b0;
      lsb_valid  <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (go) begin
            state    <= MC_BUSY;
            gnt_lsb  <= pick_lsb;
            last_lsb <= pick_lsb;
            gnt_wr   <= pick_lsb & lsb_wr;
          end
        end
        MC_BUSY: begin
          // A store already has bytes in RAM, so it finishes even across a flush.
          if (clear && !gnt_wr) begin
            state <= MC_IDLE;
          end else if (fin) begin
            state <= MC_DONE;
            if (gnt_lsb) begin
              lsb_valid <= 1'b1;
              if (!gnt_wr) lsb_rdata <= rdata;
            end else begin
              inst_valid <= 1'b1;
              inst_data  <= rdata;
            end
          end
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide synchronous RAM model (1 KiB, address masked).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        inst_req, inst_valid;
  logic [31:0] inst_addr, inst_data;
  logic        lsb_req, lsb_wr, lsb_valid;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

  logic [7:0]  ram [0:1023];
  int          wr_events = 0;
  int          checks = 0;
  int          failures = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_data(inst_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[9:0]] = mem_dout;
      wr_events++;
    end
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit lsb_side, input int maxc, output int seen);
    seen = -1;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (lsb_side ? lsb_valid : inst_valid) begin
        seen = c;
        break;
      end
    end
  endtask

  int          seen, fi, fl, fw, ni, nl, w0, exp_fw, exp_fl;
  logic [31:0] ea, wd;

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    inst_req = 1'b0; inst_addr = 32'd0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h1FF] = 8'h80;
    ram[10'h000] = 8'h67; ram[10'h001] = 8'h45; ram[10'h002] = 8'h23; ram[10'h003] = 8'h01;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", mem_dout, 8'd0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_valids", {inst_valid, lsb_valid}, 2'b00);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Word fetch: 6-cycle latency
    inst_addr = 32'h100; inst_req = 1'b1;
    wait_valid(1'b0, 10, seen);
    chk("fetch_lat", seen, 6);
    chk("fetch_data", inst_data, 32'h0000_0513);
    inst_req = 1'b0;
    step();
    chk("fetch_pulse_once", inst_valid, 1'b0);

    // Byte load: 3-cycle latency, zero-extended
    lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h1FF; lsb_req = 1'b1;
    wait_valid(1'b1, 10, seen);
    chk("ldb_lat", seen, 3);
    chk("ldb_data", lsb_rdata, 32'h0000_0080);
    lsb_req = 1'b0;
    step();
    chk("ldb_pulse_once", lsb_valid, 1'b0);
    chk("inst_data_hold", inst_data, 32'h0000_0513);

    // Half load: 4-cycle latency
    lsb_size = 2'd1; lsb_addr = 32'h100; lsb_req = 1'b1;
    wait_valid(1'b1, 10, seen);
    chk("ldh_lat", seen, 4);
    chk("ldh_data", lsb_rdata, 32'h0000_0513);
    lsb_req = 1'b0;
    step();

    // Conflict with LSB served last: fetch first, then the word load
    inst_addr = 32'h0; lsb_addr = 32'h100; lsb_size = 2'd2;
    inst_req = 1'b1; lsb_req = 1'b1;
    fi = -1; fl = -1; ni = 0; nl = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (inst_valid) begin ni++; if (fi < 0) fi = c; inst_req = 1'b0; end
      if (lsb_valid) begin nl++; if (fl < 0) fl = c; lsb_req = 1'b0; end
    end
    chk("arb_inst_cycle", fi, 6);
    chk("arb_lsb_cycle", fl, 13);
    chk("arb_pulse_counts", {ni[7:0], nl[7:0]}, 16'h0101);
    chk("arb_inst_data", inst_data, 32'h0123_4567);
    chk("arb_lsb_data", lsb_rdata, 32'h0000_0513);

    // Word store with a flush in cycle 2: all bytes still written
    lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h200; lsb_wdata = 32'hDEAD_BEEF; lsb_req = 1'b1;
    w0 = wr_events; fl = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c <= 4) begin
        ea = 32'h200 + 32'(c - 1);
        wd = 32'hDEAD_BEEF >> (8 * (c - 1));
        chk("st_bus", {mem_wr, mem_a, mem_dout}, {1'b1, ea, wd[7:0]});
      end
      clear = (c == 2);
      if (lsb_valid && fl < 0) begin fl = c; lsb_req = 1'b0; end
    end
    chk("st_valid_cycle", fl, 5);
    chk("st_write_count", wr_events - w0, 4);
    chk("st_ram", {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]}, 32'hDEAD_BEEF);
    chk("st_rdata_hold", lsb_rdata, 32'h0000_0513);
    chk("st_idle_wr", mem_wr, 1'b0);

    // Flush during fetch cycle 3: no inst_valid, then a clean refetch
    lsb_wr = 1'b0;
    inst_addr = 32'h100; inst_req = 1'b1; ni = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (inst_valid) ni++;
      if (c == 3) begin clear = 1'b1; inst_req = 1'b0; end
      else clear = 1'b0;
    end
    chk("clr_no_valid", ni, 0);
    chk("clr_data_hold", inst_data, 32'h0123_4567);
    ram[10'h000] = 8'h93;
    inst_addr = 32'h0; inst_req = 1'b1;
    wait_valid(1'b0, 10, seen);
    chk("refetch_lat", seen, 6);
    chk("refetch_data", inst_data, 32'h0123_4593);
    inst_req = 1'b0;
    step();

    // Request together with clear in IDLE is ignored
    lsb_size = 2'd0; lsb_addr = 32'h1FF; lsb_req = 1'b1; clear = 1'b1;
    step();
    lsb_req = 1'b0; clear = 1'b0; nl = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (lsb_valid) nl++;
    end
    chk("idle_clr_no_valid", nl, 0);
    chk("idle_clr_mem_a", mem_a, 32'h3);

    // rdy freeze mid-store: no double write, resume where stopped
    lsb_wr = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h300; lsb_wdata = 32'h0000_A55A; lsb_req = 1'b1;
    w0 = wr_events; fl = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) chk("frz_bus", {mem_wr, mem_a}, {1'b0, 32'h301});
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
      if (lsb_valid && fl < 0) begin fl = c; lsb_req = 1'b0; end
    end
    chk("frz_valid_cycle", fl, 6);
    chk("frz_write_count", wr_events - w0, 2);
    chk("frz_ram", {ram[10'h301], ram[10'h300]}, 16'hA55A);

    // Word load across 0xFFFFFFFF wraps to 0
    ram[10'h3FF] = 8'hAB;
    lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'hFFFF_FFFF; lsb_req = 1'b1; fl = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
      if (c == 2) chk("wrap_a2", mem_a, 32'h0);
      if (lsb_valid && fl < 0) begin fl = c; lsb_req = 1'b0; end
    end
    chk("wrap_lat", fl, 6);
    chk("wrap_data", lsb_rdata, 32'h2345_93AB);

    // IO-region byte store with the UART buffer full for cycles 1..4
`ifdef MC_IO_STALL_EN
    exp_fw = 5; exp_fl = 6;
`else
    exp_fw = 1; exp_fl = 2;
`endif
    lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h77;
    lsb_req = 1'b1; io_buffer_full = 1'b1;
    w0 = wr_events; fw = -1; fl = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 5) io_buffer_full = 1'b0;
      if (mem_wr && fw < 0) fw = c;
      if (lsb_valid && fl < 0) begin fl = c; lsb_req = 1'b0; end
    end
    chk("io_first_wr", fw, exp_fw);
    chk("io_valid_cycle", fl, exp_fl);
    chk("io_write_count", wr_events - w0, 1);
    chk("io_ram", ram[10'h000], 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
